// File: rtl/exibe_sequencia.sv
// exibe_sequencia: plays the stored game sequence back to the player.
// Walks the sequence ROM from address 0 up to the captured round limit,
// lighting each value for ON_CYCLES and blanking for OFF_CYCLES, then
// pulses pronto for one cycle.
// Optional build macro CONTA_EXIBICOES_EN adds db_exibicoes, a saturating
// count of completed presentations.
module exibe_sequencia #(
   parameter int ON_CYCLES  = 1000,
   parameter int OFF_CYCLES = 500,
   parameter int TIMER_W    = 16
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic [3:0] limite,
   input  logic [3:0] dado_mem,
   output logic [3:0] endereco,
   output logic [3:0] leds,
   output logic       exibindo,
   output logic       pronto,
   output logic [3:0] db_estado
`ifdef CONTA_EXIBICOES_EN
   ,
   output logic [7:0] db_exibicoes
`endif
);

   localparam logic [2:0] OCIOSO  = 3'd0;
   localparam logic [2:0] LE      = 3'd1;
   localparam logic [2:0] ACESO   = 3'd2;
   localparam logic [2:0] APAGADO = 3'd3;
   localparam logic [2:0] PROX    = 3'd4;
   localparam logic [2:0] FIM     = 3'd5;

   // Terminal timer values: the timer counts 0..N-1 inside a state.
   localparam logic [TIMER_W-1:0] ON_LAST  = TIMER_W'(ON_CYCLES - 1);
   localparam logic [TIMER_W-1:0] OFF_LAST = TIMER_W'(OFF_CYCLES - 1);

   logic [2:0]         state_q, state_d;
   logic [3:0]         endereco_q, endereco_d;
   logic [TIMER_W-1:0] timer_q, timer_d;
   logic [3:0]         lim_q, lim_d;

   // Next-state logic: sequencing through read, lit, blank and advance.
   always_comb begin
      state_d    = state_q;
      endereco_d = endereco_q;
      timer_d    = timer_q;
      lim_d      = lim_q;
      case (state_q)
         OCIOSO: begin
            if (iniciar) begin
               state_d    = LE;
               endereco_d = 4'd0;
               lim_d      = limite;
            end
         end
         LE: begin
            // Address was stable this cycle; ROM output is valid next cycle.
            state_d = ACESO;
            timer_d = '0;
         end
         ACESO: begin
            if (timer_q == ON_LAST) begin
               state_d = APAGADO;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         APAGADO: begin
            if (timer_q == OFF_LAST) begin
               state_d = PROX;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TIMER_W'(1);
            end
         end
         PROX: begin
            // Compare before incrementing so limit 15 never wraps the address.
            if (endereco_q == lim_q) begin
               state_d = FIM;
            end else begin
               endereco_d = endereco_q + 4'd1;
               state_d    = LE;
            end
         end
         FIM: begin
            state_d = OCIOSO;
         end
         default: begin
            state_d = OCIOSO;
         end
      endcase
   end

   // State registers with synchronous reset; reset aborts without pronto.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= OCIOSO;
         endereco_q <= 4'd0;
         timer_q    <= '0;
         lim_q      <= 4'd0;
      end else begin
         state_q    <= state_d;
         endereco_q <= endereco_d;
         timer_q    <= timer_d;
         lim_q      <= lim_d;
      end
   end

   assign endereco  = endereco_q;
   assign leds      = (state_q == ACESO) ? dado_mem : 4'd0;
   assign exibindo  = (state_q != OCIOSO) && (state_q != FIM);
   assign pronto    = (state_q == FIM);
   assign db_estado = {1'b0, state_q};

`ifdef CONTA_EXIBICOES_EN
   logic [7:0] exib_q;

   // Saturating count of presentations that reached FIM.
   always_ff @(posedge clock) begin
      if (reset) begin
         exib_q <= 8'd0;
      end else if ((state_q == FIM) && (exib_q != 8'hFF)) begin
         exib_q <= exib_q + 8'd1;
      end
   end

   assign db_exibicoes = exib_q;
`endif

endmodule
